window_sync_monitor: RTL and testbench
======================================

// Module: window_sync_monitor
// PURPOSE
//  Qualifies the per-window sync pulse in the user_clk domain before the window stage consumes it.
//  Measures the sync period and tracks lock against the expected window length.
//  Counts good syncs and errors, and regenerates a clean sync once locked.
//  Its 32-bit status word drives user_data_in of the window sync software register, so the PPC can read lock state.
// PARAMETERS
//  PERIOD_W   24    width of period counter and last_period output
//  EXP_PERIOD 1024  expected user_clk cycles between sync pulses (must be < 2**PERIOD_W - TOL)
//  TOL        0     allowed +/- deviation in cycles; a period is good iff |P-EXP_PERIOD| <= TOL
//  LOCK_COUNT 4     consecutive good periods needed to enter LOCKED (1..15)
// PORTS
//  user_clk     in   1         sole clock; all logic rising-edge
//  user_rst     in   1         asynchronous, active-high reset
//  arm          in   1         level; 0 forces IDLE
//  clear        in   1         1-cycle pulse; zeroes sync_cnt, err_cnt, err_sticky
//  sync_in      in   1         raw sync pulse, 1 cycle high per window
//  sync_out     out  1         regenerated sync, 1-cycle pulse, only in LOCKED
//  locked       out  1         1 while state==LOCKED
//  last_period  out  PERIOD_W  last measured period (good or bad)
//  status_word  out  32        [31:30] state, [29] err_sticky, [28:24] 0, [23:16] err_cnt, [15:0] sync_cnt
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, period cnt 0, good cnt 0.
//  Period counter cnt: sync_in=1 -> cnt<=1; else cnt<=cnt+1, saturating at all-ones.
//  On a sync, measured P = cnt (syncs at cycles t and t+P give P); last_period<=P in TRACK/LOCKED.
//  States, encoding as status_word[31:30]:
//   IDLE(00):   arm=1 -> SEARCH.
//   SEARCH(01): first sync_in -> TRACK, good=0; no error possible here.
//   TRACK(10):  good sync -> good++; when good reaches LOCK_COUNT -> LOCKED.
//               Bad sync -> err, good=0, stay TRACK.
//   LOCKED(11): good sync -> stay; bad sync -> err, good=0, -> TRACK.
//  Timeout, TRACK/LOCKED only: cnt==EXP_PERIOD+TOL and sync_in=0 -> err, good=0, -> SEARCH.
//  Sync on exactly that cycle is good, not a timeout.
//  err: err_cnt++ (saturate at 255), err_sticky<=1.
//  sync_cnt++ (wraps 16 bits) on every sync_in while arm=1, any non-IDLE state.
//  sync_out: registered, high the cycle after a good sync_in seen in LOCKED; 1-cycle latency.
//   Bad sync while LOCKED gives no sync_out.
//  locked and status_word are registered and reflect state after the update; 1-cycle latency.
//  arm=0 has priority over all transitions:
//   -> IDLE next cycle, good=0, no err.
//   Counters hold; sync_in is ignored for counting.
//  clear takes priority over a same-cycle increment.
//   Result 0 for sync_cnt, err_cnt and err_sticky.
//   State, good and last_period are unaffected.
//  Same-cycle sync_in and arm 0->1: arm seen in IDLE only moves to SEARCH; that sync is not counted.
//  user_rst mid-window: immediate return to reset values; first sync after arm re-enters via SEARCH.
// TESTING
//  1. Reset, arm=1, 6 syncs spaced 1024:
//     - SEARCH, then TRACK after sync1, LOCKED after sync5.
//     - sync_out after sync6 only; sync_cnt=6, err_cnt=0.
//  2. LOCKED, next sync at 1023 (TOL=0):
//     - TRACK, err_cnt=1, err_sticky=1, last_period=1023, no sync_out.
//  3. LOCKED, no sync for 1024 cycles:
//     - timeout on cnt==1024 -> SEARCH, err_cnt=1.
//     - Sync exactly at 1024 instead gives no error.
//  4. TOL=2:
//     - periods 1022, 1026 -> good.
//     - 1027 -> err, or timeout at cnt==1026 if no sync.
//  5. 300 bad periods: err_cnt saturates 255. clear pulse with a bad sync in the same cycle -> err_cnt=0, err_sticky=0.
//  6. arm=0 while LOCKED with a sync the same cycle:
//     - IDLE next cycle, locked=0, no sync_out.
//     - sync_cnt unchanged, err_cnt unchanged.
//  7. Assert user_rst mid-period:
//     - outputs 0 asynchronously.
//     - Re-arm, then lock after LOCK_COUNT+1 syncs.

Source files
------------

// File: rtl/window_sync_monitor.sv
// Qualifies the per-window sync pulse, measures its period and tracks lock against EXP_PERIOD.
// Exposes lock state, error/sync counters and a regenerated sync for the window stage and the PPC.
module window_sync_monitor #(
  parameter int PERIOD_W   = 24,
  parameter int EXP_PERIOD = 1024,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic                arm,
  input  logic                clear,
  input  logic                sync_in,
  output logic                sync_out,
  output logic                locked,
  output logic [PERIOD_W-1:0] last_period,
  output logic [31:0]         status_word
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SEARCH = 2'b01,
    ST_TRACK  = 2'b10,
    ST_LOCKED = 2'b11
  } state_t;

  localparam logic [PERIOD_W-1:0] TMO_P   = PERIOD_W'(EXP_PERIOD + TOL);
  localparam logic [PERIOD_W-1:0] CNT_MAX = {PERIOD_W{1'b1}};
  localparam logic [3:0]          LOCK_N  = 4'(LOCK_COUNT);

  function automatic logic period_ok(input logic [PERIOD_W-1:0] p);
    return (longint'(p) >= longint'(EXP_PERIOD - TOL)) &&
           (longint'(p) <= longint'(EXP_PERIOD + TOL));
  endfunction

  state_t                state_r, state_nx_s;
  logic [PERIOD_W-1:0]   cnt_r;
  logic [3:0]            good_r, good_nx_s, good_inc_s;
  logic                  err_s, period_ok_s, measure_s, count_sync_s;
  logic [15:0]           sync_cnt_r, sync_cnt_nx_s;
  logic [7:0]            err_cnt_r, err_cnt_nx_s;
  logic                  err_sticky_r, err_sticky_nx_s;
  logic [PERIOD_W-1:0]   last_period_r, last_period_nx_s;
  logic                  sync_out_r, sync_out_nx_s, locked_r;
  logic [31:0]           status_word_r;

  assign period_ok_s  = period_ok(cnt_r);
  assign good_inc_s   = good_r + 4'd1;
  assign measure_s    = arm && sync_in && ((state_r == ST_TRACK) || (state_r == ST_LOCKED));
  assign count_sync_s = arm && sync_in && (state_r != ST_IDLE);

  // Period counter: restarts at 1 on every sync so it equals the period on the next sync.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      cnt_r <= {PERIOD_W{1'b0}};
    end else if (sync_in) begin
      cnt_r <= PERIOD_W'(1);
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + PERIOD_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Lock FSM state and good-period run length.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_r <= ST_IDLE;
      good_r  <= 4'd0;
    end else begin
      state_r <= state_nx_s;
      good_r  <= good_nx_s;
    end
  end

  // Next-state logic; disarming overrides every other transition.
  always_comb begin
    state_nx_s = state_r;
    good_nx_s  = good_r;
    err_s      = 1'b0;
    if (!arm) begin
      state_nx_s = ST_IDLE;
      good_nx_s  = 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: state_nx_s = ST_SEARCH;
        ST_SEARCH: begin
          if (sync_in) begin
            state_nx_s = ST_TRACK;
            good_nx_s  = 4'd0;
          end else begin
            state_nx_s = ST_SEARCH;
          end
        end
        ST_TRACK, ST_LOCKED: begin
          if (sync_in && period_ok_s) begin
            if (state_r == ST_TRACK) begin
              good_nx_s = good_inc_s;
              if (good_inc_s == LOCK_N) begin
                state_nx_s = ST_LOCKED;
              end else begin
                state_nx_s = ST_TRACK;
              end
            end else begin
              state_nx_s = ST_LOCKED;
            end
          end else if (sync_in) begin
            err_s      = 1'b1;
            good_nx_s  = 4'd0;
            state_nx_s = ST_TRACK;
          end else if (cnt_r == TMO_P) begin
            // Window overran the tolerance with no sync: lose the phase and re-search.
            err_s      = 1'b1;
            good_nx_s  = 4'd0;
            state_nx_s = ST_SEARCH;
          end else begin
            state_nx_s = state_r;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
          good_nx_s  = 4'd0;
        end
      endcase
    end
  end

  // Next values of counters and outputs; clear beats any same-cycle increment.
  always_comb begin
    sync_cnt_nx_s    = sync_cnt_r;
    err_cnt_nx_s     = err_cnt_r;
    err_sticky_nx_s  = err_sticky_r;
    last_period_nx_s = last_period_r;
    sync_out_nx_s    = 1'b0;
    if (clear) begin
      sync_cnt_nx_s   = 16'd0;
      err_cnt_nx_s    = 8'd0;
      err_sticky_nx_s = 1'b0;
    end else begin
      if (count_sync_s) begin
        sync_cnt_nx_s = sync_cnt_r + 16'd1;
      end else begin
        sync_cnt_nx_s = sync_cnt_r;
      end
      if (err_s) begin
        err_sticky_nx_s = 1'b1;
        if (err_cnt_r != 8'hFF) begin
          err_cnt_nx_s = err_cnt_r + 8'd1;
        end else begin
          err_cnt_nx_s = err_cnt_r;
        end
      end else begin
        err_cnt_nx_s    = err_cnt_r;
        err_sticky_nx_s = err_sticky_r;
      end
    end
    if (measure_s) begin
      last_period_nx_s = cnt_r;
    end else begin
      last_period_nx_s = last_period_r;
    end
    if (measure_s && period_ok_s && (state_r == ST_LOCKED)) begin
      sync_out_nx_s = 1'b1;
    end else begin
      sync_out_nx_s = 1'b0;
    end
  end

  // Counter and output registers; status reflects the post-update state.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      sync_cnt_r    <= 16'd0;
      err_cnt_r     <= 8'd0;
      err_sticky_r  <= 1'b0;
      last_period_r <= {PERIOD_W{1'b0}};
      sync_out_r    <= 1'b0;
      locked_r      <= 1'b0;
      status_word_r <= 32'd0;
    end else begin
      sync_cnt_r    <= sync_cnt_nx_s;
      err_cnt_r     <= err_cnt_nx_s;
      err_sticky_r  <= err_sticky_nx_s;
      last_period_r <= last_period_nx_s;
      sync_out_r    <= sync_out_nx_s;
      locked_r      <= (state_nx_s == ST_LOCKED);
      status_word_r <= {state_nx_s, err_sticky_nx_s, 5'b00000, err_cnt_nx_s, sync_cnt_nx_s};
    end
  end

  assign sync_out    = sync_out_r;
  assign locked      = locked_r;
  assign last_period = last_period_r;
  assign status_word = status_word_r;

endmodule

// File: tb/tb_window_sync_monitor.sv
// Bench for window_sync_monitor: two instances (TOL=0 and TOL=2) share stimulus and are checked
// every cycle against an elapsed-time reference model, plus a directed table and corner sequences.
module tb_window_sync_monitor;

  localparam int  PW   = 24;
  localparam int  EXP  = 1024;
  localparam int  LOCK = 4;
  localparam longint MAXC = (longint'(1) << PW) - 1;
  localparam int  S_IDLE = 0, S_SEARCH = 1, S_TRACK = 2, S_LOCKED = 3;

  logic user_clk = 1'b0;
  logic user_rst = 1'b1;
  logic arm = 1'b0, clear = 1'b0, sync_in = 1'b0;
  logic so0, lk0, so2, lk2;
  logic [PW-1:0] lp0, lp2;
  logic [31:0] sw0, sw2;

  int vectors = 0;
  int miscompares = 0;
  longint cyc = 0;

  typedef struct {
    int     st;
    int     good;
    longint last_sync;
    int     sc;
    int     ec;
    bit     sticky;
    int     lp;
    bit     so;
  } model_t;

  typedef struct {
    int       gap;
    bit       sync;
    bit [1:0] st;
    int       sc;
    int       ec;
    int       lp;
    bit       so;
  } vec_t;

  model_t m0, m2;
  vec_t   tbl[13];

  window_sync_monitor #(.PERIOD_W(PW), .EXP_PERIOD(EXP), .TOL(0), .LOCK_COUNT(LOCK)) dut0 (
    .user_clk(user_clk), .user_rst(user_rst), .arm(arm), .clear(clear), .sync_in(sync_in),
    .sync_out(so0), .locked(lk0), .last_period(lp0), .status_word(sw0));

  window_sync_monitor #(.PERIOD_W(PW), .EXP_PERIOD(EXP), .TOL(2), .LOCK_COUNT(LOCK)) dut2 (
    .user_clk(user_clk), .user_rst(user_rst), .arm(arm), .clear(clear), .sync_in(sync_in),
    .sync_out(so2), .locked(lk2), .last_period(lp2), .status_word(sw2));

  always #5 user_clk = ~user_clk;

  // Reference: the period is the time since the previous sync, not a replica of the counter.
  function automatic model_t mstep(model_t m, bit a, bit c, bit s, int tol, longint now);
    model_t n;
    longint el;
    bit ok;
    bit err;
    n   = m;
    el  = now - m.last_sync;
    if (el > MAXC) el = MAXC;
    ok  = (el >= EXP - tol) && (el <= EXP + tol);
    err = 1'b0;
    n.so = 1'b0;
    if (!a) begin
      n.st = S_IDLE; n.good = 0;
    end else if (m.st == S_IDLE) begin
      n.st = S_SEARCH;
    end else if (m.st == S_SEARCH) begin
      if (s) begin n.st = S_TRACK; n.good = 0; end
    end else if (s) begin
      n.lp = int'(el);
      if (!ok) begin
        err = 1'b1; n.good = 0; n.st = S_TRACK;
      end else if (m.st == S_LOCKED) begin
        n.so = 1'b1;
      end else begin
        n.good = m.good + 1;
        if (n.good == LOCK) n.st = S_LOCKED;
      end
    end else if (el == EXP + tol) begin
      err = 1'b1; n.good = 0; n.st = S_SEARCH;
    end
    if (a && m.st != S_IDLE && s) n.sc = (m.sc + 1) % 65536;
    if (err) begin
      n.ec = (m.ec < 255) ? m.ec + 1 : 255;
      n.sticky = 1'b1;
    end
    if (c) begin n.sc = 0; n.ec = 0; n.sticky = 1'b0; end
    if (s) n.last_sync = now;
    return n;
  endfunction

  function automatic model_t mreset(longint now);
    model_t m;
    m = '{st: S_IDLE, good: 0, last_sync: now, sc: 0, ec: 0, sticky: 1'b0, lp: 0, so: 1'b0};
    return m;
  endfunction

  function automatic logic [31:0] model_sw(model_t m);
    return {2'(m.st), m.sticky, 5'b00000, 8'(m.ec), 16'(m.sc)};
  endfunction

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, got, exp, $time);
    end
  endfunction

  function automatic void chk_model(string nm, model_t m, logic so, logic lk, logic [PW-1:0] lp,
                                    logic [31:0] sw);
    logic [31:0] esw;
    esw = model_sw(m);
    vectors++;
    if (so !== m.so || lk !== (m.st == S_LOCKED) || lp !== PW'(m.lp) || sw !== esw) begin
      miscompares++;
      $display("FAIL %s model: got so=%b lk=%b lp=%0d sw=0x%08h expected so=%b lk=%b lp=%0d sw=0x%08h (t=%0t)",
               nm, so, lk, lp, sw, m.so, (m.st == S_LOCKED), m.lp, esw, $time);
    end
  endfunction

  task automatic tick(input bit a, input bit c, input bit s);
    @(negedge user_clk);
    arm = a; clear = c; sync_in = s;
    @(posedge user_clk);
    m0 = mstep(m0, a, c, s, 0, cyc);
    m2 = mstep(m2, a, c, s, 2, cyc);
    cyc++;
    #1;
    chk_model("dut0", m0, so0, lk0, lp0, sw0);
    chk_model("dut2", m2, so2, lk2, lp2, sw2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge user_clk);
    user_rst = 1'b1; arm = 1'b0; clear = 1'b0; sync_in = 1'b0;
    @(posedge user_clk);
    @(negedge user_clk);
    user_rst = 1'b0;
    m0 = mreset(cyc);
    m2 = mreset(cyc);
  endtask

  task automatic lock_up();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < LOCK; i++) begin
      idle(EXP - 1);
      tick(1'b1, 1'b0, 1'b1);
    end
  endtask

  initial begin
    tbl[0]  = '{5,    1'b1, 2'd2, 1,  0, 0,    1'b0};
    tbl[1]  = '{1023, 1'b1, 2'd2, 2,  0, 1024, 1'b0};
    tbl[2]  = '{1023, 1'b1, 2'd2, 3,  0, 1024, 1'b0};
    tbl[3]  = '{1023, 1'b1, 2'd2, 4,  0, 1024, 1'b0};
    tbl[4]  = '{1023, 1'b1, 2'd3, 5,  0, 1024, 1'b0};
    tbl[5]  = '{1023, 1'b1, 2'd3, 6,  0, 1024, 1'b1};
    tbl[6]  = '{1022, 1'b1, 2'd2, 7,  1, 1023, 1'b0};
    tbl[7]  = '{1023, 1'b1, 2'd2, 8,  1, 1024, 1'b0};
    tbl[8]  = '{1023, 1'b1, 2'd2, 9,  1, 1024, 1'b0};
    tbl[9]  = '{1023, 1'b1, 2'd2, 10, 1, 1024, 1'b0};
    tbl[10] = '{1023, 1'b1, 2'd3, 11, 1, 1024, 1'b0};
    tbl[11] = '{1023, 1'b1, 2'd3, 12, 1, 1024, 1'b1};
    tbl[12] = '{1023, 1'b0, 2'd1, 12, 2, 1024, 1'b0};

    // Reset state
    do_reset();
    #1;
    chk("rst_sw", sw0, 32'd0);
    chk("rst_lp", 32'(lp0), 32'd0);
    chk("rst_lk_so", {30'd0, lk0, so0}, 32'd0);

    // Lock acquisition, early sync, relock, sync exactly at EXP, timeout (TOL=0)
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      logic [31:0] esw;
      idle(tbl[i].gap);
      tick(1'b1, 1'b0, tbl[i].sync);
      esw = {tbl[i].st, (tbl[i].ec != 0), 5'b00000, 8'(tbl[i].ec), 16'(tbl[i].sc)};
      chk($sformatf("tbl%0d_sw", i), sw0, esw);
      chk($sformatf("tbl%0d_lp", i), 32'(lp0), 32'(tbl[i].lp));
      chk($sformatf("tbl%0d_so", i), {31'd0, so0}, {31'd0, tbl[i].so});
      chk($sformatf("tbl%0d_lk", i), {31'd0, lk0}, {31'd0, (tbl[i].st == 2'd3)});
    end

    // Tolerance window on the TOL=2 instance
    do_reset();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    idle(1021);
    tick(1'b1, 1'b0, 1'b1);
    chk("tol_1022_sw", sw2, {2'b10, 1'b0, 5'b0, 8'd0, 16'd2});
    chk("tol_1022_lp", 32'(lp2), 32'd1022);
    idle(1025);
    tick(1'b1, 1'b0, 1'b1);
    chk("tol_1026_sw", sw2, {2'b10, 1'b0, 5'b0, 8'd0, 16'd3});
    chk("tol_1026_lp", 32'(lp2), 32'd1026);
    idle(1025);
    tick(1'b1, 1'b0, 1'b0);
    chk("tol_tmo_sw", sw2, {2'b01, 1'b1, 5'b0, 8'd1, 16'd3});

    // Error counter saturation, then clear colliding with a bad sync
    do_reset();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b1);
    end
    chk("sat_ec0", 32'(sw0[29:16]), {18'd0, 1'b1, 5'd0, 8'd255});
    chk("sat_ec2", 32'(sw2[29:16]), {18'd0, 1'b1, 5'd0, 8'd255});
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    chk("clr_sw", sw0, {2'b10, 1'b0, 5'b0, 8'd0, 16'd0});

    // Disarm while locked with a coincident sync
    do_reset();
    lock_up();
    chk("arm_lk_before", {31'd0, lk0}, 32'd1);
    idle(EXP - 1);
    tick(1'b0, 1'b0, 1'b1);
    chk("disarm_sw", sw0, {2'b00, 1'b0, 5'b0, 8'd0, 16'd5});
    chk("disarm_lk_so", {30'd0, lk0, so0}, 32'd0);
    chk("disarm_lp", 32'(lp0), 32'd1024);

    // Asynchronous reset in the middle of a window
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    idle(300);
    #3;
    user_rst = 1'b1;
    #1;
    chk("arst_sw", sw0, 32'd0);
    chk("arst_lp", 32'(lp0), 32'd0);
    chk("arst_lk_so", {30'd0, lk0, so0}, 32'd0);
    @(negedge user_clk);
    @(posedge user_clk);
    @(negedge user_clk);
    user_rst = 1'b0;
    m0 = mreset(cyc);
    m2 = mreset(cyc);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < LOCK; i++) begin
      chk($sformatf("relock_pre%0d", i), {31'd0, lk0}, 32'd0);
      idle(EXP - 1);
      tick(1'b1, 1'b0, 1'b1);
    end
    chk("relock_lk", {31'd0, lk0}, 32'd1);

    // Randomised windows against the reference model
    for (int w = 0; w < 24; w++) begin
      int kind;
      int p;
      kind = $urandom_range(0, 9);
      if (kind <= 5) p = $urandom_range(EXP - 3, EXP + 3);
      else if (kind == 6) p = $urandom_range(1, 50);
      else p = $urandom_range(EXP + 3, EXP + 8);
      if (kind == 8) begin
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, $urandom_range(0, 1) == 1);
      end
      for (int k = 0; k < p - 1; k++) tick(1'b1, ($urandom_range(0, 299) == 0), 1'b0);
      tick(1'b1, (kind == 9), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
